alu_shifter_pipe: RTL and testbench
===================================

// Module: alu_shifter_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter for the processor ALU/multicycle unit.
//  Supports logical left, logical right, arithmetic right and rotate right.
//  Uses log2(WIDTH) register stages, one shift-amount bit per stage (MSB first).
//  Valid/ready handshake on both sides; full-throughput, stall-safe under backpressure.
// PARAMETERS
//  WIDTH    32  data width; power of two, >= 2
//  TAG_W    5   sideband tag width (e.g. destination reg), carried unchanged
//  SHAMT_W  $clog2(WIDTH)  localparam, shift-amount width = stage count S
// PORTS
//  clock      in   1        rising-edge clock
//  reset_n    in   1        asynchronous, active-low reset
//  in_valid   in   1        input operation present
//  in_ready   out  1        block accepts input this cycle
//  in_data    in   WIDTH    operand A
//  in_shamt   in   SHAMT_W  shift amount, 0..WIDTH-1
//  in_mode    in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR
//  in_tag     in   TAG_W    sideband, returned with result
//  out_valid  out  1        result present
//  out_ready  in   1        consumer accepts result this cycle
//  out_data   out  WIDTH    shifted result
//  out_tag    out  TAG_W    tag of that result
// BEHAVIOUR
//  - Reset (reset_n=0, async): all stage valids=0 -> out_valid=0; out_data=0, out_tag=0;
//    in_ready=1 once reset_n=1. Data/tag/shamt/mode regs cleared to 0.
//  - Transfer in: in_valid & in_ready at rising edge. Transfer out: out_valid & out_ready.
//  - Pipeline: S stages, stage k (k=0..S-1) applies shift by 2^(S-1-k) if the
//    captured shamt bit [S-1-k] is 1, else passes through. Each stage registers
//    data, remaining shamt, mode, tag and valid.
//  - Latency: S cycles from input transfer to out_valid with no stall (S=5 @ WIDTH=32).
//  - Throughput: one op/cycle when out_ready held 1.
//  - Stall rule: stage k advances if stage k+1 is empty or stage k+1 advances;
//    last stage advances iff out_ready. Bubbles collapse (an empty stage always loads).
//  - in_ready = !v[0] | adv[0]; combinational from out_ready via the advance chain.
//  - Held stage keeps data/tag stable; out_data/out_tag stable while out_valid & !out_ready.
//  - Simultaneous in/out transfer with pipe full: both occur, occupancy unchanged.
//  - Shift rules per stage, amount n:
//      SLL: {x[W-1-n:0], n'b0}
//      SRL: {n'b0, x[W-1:n]}
//      SRA: {n{x[W-1]}, x[W-1:n]}  (sign of current stage input = original sign)
//      ROR: {x[n-1:0], x[W-1:n]}
//  - shamt=0: result == in_data for every mode, still S-cycle latency.
//  - in_mode/in_shamt sampled only on input transfer; ignored when !in_valid.
//  - No reordering: results emerge in input order with their tags.
//  - Reset mid-operation: all in-flight ops discarded, no out_valid after reset
//    until a new op is accepted.
//  - No X on outputs when out_valid=0 (registered zeros/held values only).
// TESTING (WIDTH=32, TAG_W=5)
//  1. SLL 0x00000001 shamt 31 tag 3 -> after 5 cycles out_data=0x80000000, out_tag=3.
//  2. SRA 0x80000000 shamt 4 -> 0xF8000000; SRL same input -> 0x08000000;
//     SRA 0x7FFFFFF0 shamt 4 -> 0x07FFFFFF.
//  3. ROR 0x12345678 shamt 8 -> 0x78123456; any mode, shamt 0 on 0xDEADBEEF -> 0xDEADBEEF.
//  4. Back-to-back 8 ops, tags 0..7, out_ready=1 -> 8 results on consecutive
//     cycles, first 5 cycles after first accept, tags in order.
//  5. Fill pipe, drop out_ready for 3 cycles -> in_ready=0 once 5 ops held,
//     out_data stable; raise out_ready -> no op lost or duplicated.
//  6. Assert reset_n=0 with 3 ops in flight -> out_valid=0 immediately (async);
//     after release no stale result appears; next op returns after 5 cycles.

Source files
------------

// File: rtl/alu_shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR). One register stage per shift-amount bit, MSB first,
// with a valid/ready handshake on both sides and a collapsing-bubble stall chain.
module alu_shifter_pipe #(
   parameter  int unsigned WIDTH   = 32,
   parameter  int unsigned TAG_W   = 5,
   localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int unsigned S        = SHAMT_W;
   localparam logic [1:0]  MODE_SLL = 2'b00;
   localparam logic [1:0]  MODE_SRL = 2'b01;
   localparam logic [1:0]  MODE_SRA = 2'b10;

   logic [S-1:0]       v_q;
   logic [WIDTH-1:0]   data_q  [S];
   logic [SHAMT_W-1:0] shamt_q [S];
   logic [1:0]         mode_q  [S];
   logic [TAG_W-1:0]   tag_q   [S];

   logic [S-1:0]       ld;
   logic               full;
   logic [S-1:0]       src_v;
   logic [WIDTH-1:0]   src_d     [S];
   logic [WIDTH-1:0]   nxt_d     [S];
   logic [SHAMT_W-1:0] src_shamt [S];
   logic [1:0]         src_mode  [S];
   logic [TAG_W-1:0]   src_tag   [S];

   // Fixed-distance shift of one stage; n never exceeds WIDTH/2.
   function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x,
                                                 input logic [1:0]       mode,
                                                 input int unsigned      n);
      logic [WIDTH-1:0] r;
      case (mode)
         MODE_SLL: r = x << n;
         MODE_SRL: r = x >> n;
         MODE_SRA: r = WIDTH'($signed(x) >>> n);
         default:  r = (x >> n) | (x << (WIDTH - n));
      endcase
      return r;
   endfunction

   // A stage loads when it or any stage downstream is empty, or the consumer takes the head.
   always_comb begin
      full = 1'b1;
      ld   = '0;
      for (int k = int'(S) - 1; k >= 0; k--) begin
         full  = full & v_q[k];
         ld[k] = out_ready | ~full;
      end
   end

   // Per-stage source selection and conditional shift by 2^(S-1-k).
   always_comb begin
      src_v[0]     = in_valid;
      src_d[0]     = in_data;
      src_shamt[0] = in_shamt;
      src_mode[0]  = in_mode;
      src_tag[0]   = in_tag;
      for (int k = 1; k < int'(S); k++) begin
         src_v[k]     = v_q[k-1];
         src_d[k]     = data_q[k-1];
         src_shamt[k] = shamt_q[k-1];
         src_mode[k]  = mode_q[k-1];
         src_tag[k]   = tag_q[k-1];
      end
      for (int k = 0; k < int'(S); k++) begin
         nxt_d[k] = src_shamt[k][int'(S) - 1 - k]
                  ? shift_by(src_d[k], src_mode[k], 32'(1) << (int'(S) - 1 - k))
                  : src_d[k];
      end
   end

   // Stage registers; payload only updates on a valid load so idle outputs hold their value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         v_q <= '0;
         for (int k = 0; k < int'(S); k++) begin
            data_q[k]  <= '0;
            shamt_q[k] <= '0;
            mode_q[k]  <= '0;
            tag_q[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < int'(S); k++) begin
            if (ld[k]) begin
               v_q[k] <= src_v[k];
               if (src_v[k]) begin
                  data_q[k]  <= nxt_d[k];
                  shamt_q[k] <= src_shamt[k];
                  mode_q[k]  <= src_mode[k];
                  tag_q[k]   <= src_tag[k];
               end
            end
         end
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = v_q[S-1];
   assign out_data  = data_q[S-1];
   assign out_tag   = tag_q[S-1];

endmodule

// File: tb/tb_alu_shifter_pipe.sv
// Self-checking bench for alu_shifter_pipe: directed cases plus randomized traffic
// scored against a whole-amount shift model.
module tb_alu_shifter_pipe;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  t;
   } res_t;

   res_t q[$];
   int   in_cyc[$];
   int   out_cyc[$];
   int   out_tags[$];
   int   cyc   = 0;
   int   n_acc = 0;
   int   n_out = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   alu_shifter_pipe dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_shamt (in_shamt),
      .in_mode  (in_mode),
      .in_tag   (in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_tag  (out_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Whole-amount reference: SRA fills with the sign, ROR slides a doubled word.
   function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                             input logic [1:0] m);
      logic [63:0] dbl;
      logic [31:0] fill;
      case (m)
         2'd0:    return a << s;
         2'd1:    return a >> s;
         2'd2: begin
            fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
            return (a >> s) | fill;
         end
         default: begin
            dbl = {a, a} >> s;
            return dbl[31:0];
         end
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] m, input logic [4:0] t);
      in_valid = v;
      in_data  = d;
      in_shamt = s;
      in_mode  = m;
      in_tag   = t;
   endtask

   // One clock: settle, score the output transfer, log the input transfer, advance to next negedge.
   task automatic tick();
      res_t e;
      #1;
      if (out_valid && out_ready) begin
         check("out_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("sb_data", out_data, e.d);
            check("sb_tag", 32'(out_tag), 32'(e.t));
         end
         out_cyc.push_back(cyc);
         out_tags.push_back(int'(out_tag));
         n_out++;
      end
      if (in_valid && in_ready) begin
         e.d = ref_shift(in_data, in_shamt, in_mode);
         e.t = in_tag;
         q.push_back(e);
         in_cyc.push_back(cyc);
         n_acc++;
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
   endtask

   // Single op on an idle pipe: latency, spec constant result, tag, then drain.
   task automatic single(input string name, input logic [1:0] m, input logic [31:0] d,
                         input logic [4:0] s, input logic [4:0] t, input logic [31:0] exp);
      int cnt;
      out_ready = 1'b1;
      drive(1'b1, d, s, m, t);
      tick();
      in_valid = 1'b0;
      cnt = 1;
      while (!out_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      check({name, "_lat"}, 32'(cnt), 32'd5);
      check({name, "_data"}, out_data, exp);
      check({name, "_tag"}, 32'(out_tag), 32'(t));
      tick();
   endtask

   initial begin
      int   acc0;
      int   out0;
      int   valid_seen;
      logic [31:0] held_d;
      logic [4:0]  held_t;

      reset_n   = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 32'h0, 5'd0, 2'd0, 5'd0);
      @(negedge clock);
      @(negedge clock);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      reset_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clock);

      single("sll31", 2'd0, 32'h0000_0001, 5'd31, 5'd3, 32'h8000_0000);
      single("sra_neg", 2'd2, 32'h8000_0000, 5'd4, 5'd1, 32'hF800_0000);
      single("srl_neg", 2'd1, 32'h8000_0000, 5'd4, 5'd2, 32'h0800_0000);
      single("sra_pos", 2'd2, 32'h7FFF_FFF0, 5'd4, 5'd4, 32'h07FF_FFFF);
      single("ror8", 2'd3, 32'h1234_5678, 5'd8, 5'd5, 32'h7812_3456);
      for (int m = 0; m < 4; m++)
         single("shamt0", 2'(m), 32'hDEAD_BEEF, 5'd0, 5'(m), 32'hDEAD_BEEF);

      // Back-to-back stream with out_ready held high.
      in_cyc.delete();
      out_cyc.delete();
      out_tags.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'(i));
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("b2b_count", 32'(out_cyc.size()), 32'd8);
      if (out_cyc.size() == 8 && in_cyc.size() == 8) begin
         check("b2b_first_lat", 32'(out_cyc[0] - in_cyc[0]), 32'd5);
         for (int i = 1; i < 8; i++) begin
            check("b2b_consec", 32'(out_cyc[i] - out_cyc[i-1]), 32'd1);
            check("b2b_tag_order", 32'(out_tags[i]), 32'(i));
         end
      end

      // Backpressure: fill the pipe, hold, then release with a simultaneous in/out transfer.
      out_ready = 1'b0;
      acc0 = n_acc;
      out0 = n_out;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'(10 + i));
         tick();
      end
      check("stall_accepted", 32'(n_acc - acc0), 32'd5);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      held_d = out_data;
      held_t = out_tag;
      for (int i = 0; i < 3; i++) tick();
      check("stall_data_stable", out_data, held_d);
      check("stall_tag_stable", 32'(out_tag), 32'(held_t));
      check("stall_still_full", 32'(n_acc - acc0), 32'd5);
      out_ready = 1'b1;
      drive(1'b1, 32'hCAFE_F00D, 5'd13, 2'd3, 5'd30);
      #1;
      check("full_in_ready_comb", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("stall_outs", 32'(n_out - out0), 32'd6);
      check("stall_drained", 32'(q.size()), 32'd0);

      // Asynchronous reset with ops in flight.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'(20 + i));
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_data", out_data, 32'h0);
      q.delete();
      @(negedge clock);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      valid_seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) valid_seen++;
         tick();
      end
      check("no_stale_after_rst", 32'(valid_seen), 32'd0);
      single("post_rst", 2'd1, 32'hF000_0000, 5'd28, 5'd9, 32'h0000_000F);

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
               2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
         out_ready = 1'($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("rand_drained", 32'(q.size()), 32'd0);
      check("rand_idle_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
